// File: rtl/aes128_dec_iter_if.sv
// Handshake bundle for aes128_dec_iter: ciphertext/key request side and plaintext response side.
interface aes128_dec_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dec_data;
    logic         busy;

    modport master (
        output in_valid, data, key, out_ready,
        input  in_ready, out_valid, dec_data, busy
    );

    modport slave (
        input  in_valid, data, key, out_ready,
        output in_ready, out_valid, dec_data, busy
    );
endinterface

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, with on-the-fly inverse key schedule.
// Optional AES_DEC_KEY_CACHE_EN keeps the last cipher key and its round key 10 to skip expansion.
module aes128_dec_iter #(
    parameter bit CLR_ON_DONE = 1'b1
) (
    input logic              clk,
    input logic              rst,
    aes128_dec_iter_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StKeyExp, StInit, StRound, StDone} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        logic [7:0] t;
        t = b ^ 8'h1b;
        return b[0] ? {1'b1, t[7:1]} : {1'b0, b[7:1]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n3 = k[31:0] ^ k[63:32];
        n2 = k[63:32] ^ k[95:64];
        n1 = k[95:64] ^ k[127:96];
        n0 = k[127:96] ^ sub_rot_word(n3) ^ {rc, 24'h0};
        return {n0, n1, n2, n3};
    endfunction

    // Byte i sits at [127-8i -: 8], row i%4, column i/4; row r rotates right by r.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] =
                    inv_sbox(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] ct_q, ct_d, rk_q, rk_d, st_q, st_d, dec_data_q, dec_data_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] rk_fwd, rk_inv, rnd_t;
`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] key_cache_q, key_cache_d, rk10_cache_q, rk10_cache_d;
    logic         cache_vld_q, cache_vld_d;
`endif

    always_comb begin
        state_d     = state_q;
        ct_d        = ct_q;
        rk_d        = rk_q;
        st_d        = st_q;
        rcon_d      = rcon_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        dec_data_d  = dec_data_q;
`ifdef AES_DEC_KEY_CACHE_EN
        key_cache_d  = key_cache_q;
        rk10_cache_d = rk10_cache_q;
        cache_vld_d  = cache_vld_q;
`endif
        rk_fwd = key_fwd(rk_q, rcon_q);
        rk_inv = key_inv(rk_q, rcon_q);
        rnd_t  = inv_shift_sub(st_q) ^ rk_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    ct_d  = bus.data;
                    cnt_d = 4'd0;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (cache_vld_q && (bus.key == key_cache_q)) begin
                        rk_d    = rk10_cache_q;
                        rcon_d  = 8'h36;
                        state_d = StInit;
                    end else begin
                        // Cache entry is rebuilt when this expansion completes
                        rk_d        = bus.key;
                        rcon_d      = 8'h01;
                        key_cache_d = bus.key;
                        cache_vld_d = 1'b0;
                        state_d     = StKeyExp;
                    end
`else
                    rk_d    = bus.key;
                    rcon_d  = 8'h01;
                    state_d = StKeyExp;
`endif
                end
            end
            StKeyExp: begin
                rk_d  = rk_fwd;
                cnt_d = cnt_q + 4'd1;
                // rcon stays at 0x36 on the last step; it seeds the backward schedule
                if (cnt_q == 4'd9) begin
                    state_d = StInit;
`ifdef AES_DEC_KEY_CACHE_EN
                    rk10_cache_d = rk_fwd;
                    cache_vld_d  = 1'b1;
`endif
                end else begin
                    rcon_d = xtime(rcon_q);
                end
            end
            StInit: begin
                st_d    = ct_q ^ rk_q;
                rk_d    = rk_inv;
                rcon_d  = inv_xtime(rcon_q);
                cnt_d   = 4'd9;
                state_d = StRound;
            end
            StRound: begin
                if (cnt_q != 4'd0) begin
                    st_d   = inv_mix(rnd_t);
                    rk_d   = rk_inv;
                    rcon_d = inv_xtime(rcon_q);
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    st_d        = rnd_t;
                    dec_data_d  = rnd_t;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                    if (CLR_ON_DONE) begin
                        ct_d       = '0;
                        rk_d       = '0;
                        st_d       = '0;
                        dec_data_d = '0;
                        rcon_d     = '0;
                        cnt_d      = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ct_q        <= '0;
            rk_q        <= '0;
            st_q        <= '0;
            rcon_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            dec_data_q  <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            key_cache_q  <= '0;
            rk10_cache_q <= '0;
            cache_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ct_q        <= ct_d;
            rk_q        <= rk_d;
            st_q        <= st_d;
            rcon_q      <= rcon_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            dec_data_q  <= dec_data_d;
`ifdef AES_DEC_KEY_CACHE_EN
            key_cache_q  <= key_cache_d;
            rk10_cache_q <= rk10_cache_d;
            cache_vld_q  <= cache_vld_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.dec_data  = dec_data_q;
endmodule

// File: tb/tb_aes128_dec_iter.sv
// Self-checking bench for aes128_dec_iter: known-answer vectors, backpressure, busy noise, reset abort.
module tb_aes128_dec_iter;
    logic clk = 1'b0;
    logic rst;

    aes128_dec_iter_if bus ();

    aes128_dec_iter #(
        .CLR_ON_DONE(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        int unsigned  lat;
    } exp_t;

    typedef struct {
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] pt;
        int unsigned  hold;
        bit           noise;
    } vec_t;

    localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    exp_t         sb[$];
    vec_t         vecs[6];
    int unsigned  n_pass = 0;
    int unsigned  n_checks = 0;
    logic         cache_vld = 1'b0;
    logic [127:0] cache_key = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        cache_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        exp_t        e, got;
        int unsigned edges;
        @(negedge clk);
        check("in_ready_idle", 128'(bus.in_ready), 128'd1);
        bus.key      = v.key;
        bus.data     = v.data;
        bus.in_valid = 1'b1;
        @(posedge clk);
        e.pt = v.pt;
`ifdef AES_DEC_KEY_CACHE_EN
        e.lat     = (cache_vld && cache_key == v.key) ? 11 : 21;
        cache_vld = 1'b1;
        cache_key = v.key;
`else
        e.lat = 21;
`endif
        sb.push_back(e);
        #1;
        bus.in_valid = 1'b0;
        check("busy_after_accept", 128'(bus.busy), 128'd1);
        edges = 0;
        while (edges < 40 && !bus.out_valid) begin
            @(posedge clk);
            edges++;
            #1;
            if (v.noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.data     = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.key      = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        bus.in_valid = 1'b0;
        if (!bus.out_valid) begin
            n_checks++;
            $display("FAIL timeout: out_valid low after %0d edges, required at %0d", edges, e.lat);
            do_reset();
            return;
        end
        got = sb.pop_front();
        check("latency", 128'(edges), 128'(got.lat));
        check("plaintext", bus.dec_data, got.pt);
        check("in_ready_done", 128'(bus.in_ready), 128'd0);
        for (int i = 0; i < int'(v.hold); i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 128'(bus.out_valid), 128'd1);
            check("hold_dec_data", bus.dec_data, got.pt);
            check("hold_in_ready", 128'(bus.in_ready), 128'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_cleared", 128'(bus.out_valid), 128'd0);
        check("in_ready_back", 128'(bus.in_ready), 128'd1);
        check("busy_cleared", 128'(bus.busy), 128'd0);
        check("dec_data_scrubbed", bus.dec_data, 128'd0);
    endtask

    initial begin
        vec_t c1;
        bit   seen;
        vecs[0] = '{KeyC1, CtC1, PtC1, 0, 1'b0};
        vecs[1] = '{KeyC1, CtC1, PtC1, 15, 1'b0};
        vecs[2] = '{KeyB, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734, 0, 1'b0};
        vecs[3] = '{KeyB, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    128'h6bc1bee22e409f96e93d7e117393172a, 2, 1'b0};
        vecs[4] = '{KeyC1, CtC1, PtC1, 0, 1'b1};
        vecs[5] = '{KeyB, 128'hf5d3d58503b9699de785895a96fdbaaf,
                    128'hae2d8a571e03ac9c9eb76fac45af8e51, 1, 1'b1};
        c1 = vecs[0];

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data      = '0;
        bus.key       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_dec_data", bus.dec_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_op(vecs[i]);

        // Abort a decryption in the middle of its rounds
        @(negedge clk);
        bus.key      = KeyC1;
        bus.data     = CtC1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("busy_before_abort", 128'(bus.busy), 128'd1);
        rst = 1'b1;
        sb.delete();
        cache_vld = 1'b0;
        #1;
        check("abort_out_valid", 128'(bus.out_valid), 128'd0);
        check("abort_in_ready", 128'(bus.in_ready), 128'd1);
        check("abort_busy", 128'(bus.busy), 128'd0);
        check("abort_dec_data", bus.dec_data, 128'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("no_output_after_abort", 128'(seen), 128'd0);

        run_op(c1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/aes128_dec_iter.md
Name: aes128_dec_iter

Overview:
- Iterative AES-128 inverse cipher (FIPS-197). Turns 128-bit ciphertext plus cipher key back into plaintext.
- Companion to the unrolled combinational encryption datapath in the crypto co-processor. Executes one round per clock to save area.
- Expands the forward key schedule to round key 10 on the fly, then runs the inverse key schedule backwards alongside the rounds.

Parameters:
- CLR_ON_DONE, 1: when 1, state and round-key registers are zeroed on the output-handshake edge (key scrubbing); when 0, they hold their last values.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  ciphertext/key offered
- in_ready  output  1  block idle, can accept
- data  input  128  ciphertext; [127:120] = byte 0 (FIPS column-major order)
- key  input  128  cipher key, same byte order
- out_valid  output  1  plaintext valid, held until consumed
- out_ready  input  1  consumer accepts plaintext
- dec_data  output  128  plaintext
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock; reset is asynchronous and active-high on rst.
- Reset values: in_ready=1, out_valid=0, busy=0, dec_data=0, all internal registers 0, FSM=IDLE.
- States: IDLE, KEYEXP, INIT, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - Accept happens on an edge with in_valid=1: latch data into ct_r and key into rk_r, set rcon=0x01, cnt=0, go to KEYEXP.
- KEYEXP, 10 cycles:
  - Each edge: rk_r <= forward expansion of rk_r with rcon; rcon <= xtime(rcon), where 0x80 -> 0x1b.
  - After the 10th edge, rk_r = round key 10 and rcon = 0x36. Go to INIT.
- INIT, 1 cycle:
  - st_r <= ct_r ^ rk_r.
  - rk_r <= inverse expansion using rcon = 0x36:
    - w'3=w3^w2, w'2=w2^w1, w'1=w1^w0
    - w'0 = w0 ^ SubWord(RotWord(w'3)) ^ {rcon,24'h0}
  - rcon <= inverse xtime (0x1b -> 0x80). Set rnd=9 and go to ROUND.
- ROUND, 10 cycles:
  - Each edge: t = InvSubBytes(InvShiftRows(st_r)) ^ rk_r.
  - For rnd>=1: st_r <= InvMixColumns(t), rk_r <= inverse expansion, rnd <= rnd-1.
  - For rnd=0: st_r <= t, dec_data <= t, out_valid <= 1, go to DONE.
- Latency: out_valid rises on the 21st rising edge after the accept edge.
- DONE:
  - out_valid=1 and dec_data stable until an edge with out_ready=1.
  - On that edge: out_valid <= 0, go to IDLE, scrub registers if CLR_ON_DONE=1.
  - in_ready stays 0 in DONE; there is no same-cycle turnaround, so the next accept is possible one cycle later.
- in_valid while not IDLE is ignored. data/key are sampled only on the accept edge.
- rst asserted mid-operation: everything returns immediately to reset values and no output is produced.
- dec_data keeps its value in IDLE when CLR_ON_DONE=0; it is zeroed when CLR_ON_DONE=1.
- All GF(2^8) arithmetic uses polynomial 0x11b. InvMixColumns matrix is {0e,0b,0d,09}.

Optional Feature:
- Macro: AES_DEC_KEY_CACHE_EN
- Defined:
  - Adds a 128-bit cipher-key cache, the cached round key 10, and a cache-valid bit. All are cleared by rst and are not scrubbed by CLR_ON_DONE.
  - On accept, if valid=1 and key equals the cached key: load rk_r with the cached round key 10, set rcon=0x36, skip KEYEXP and go straight to INIT. Latency becomes 11 edges.
  - On leaving KEYEXP, store key and round key 10 into the cache and set valid=1.
- Not defined: every operation runs KEYEXP; latency is always 21.

Test Plan:
- FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, data=69c4e0d86a7b0430d8cdb78070b4c55a -> dec_data=00112233445566778899aabbccddeeff, out_valid exactly 21 edges after accept.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, data=3925841d02dc09fbdc118597196a0b32 -> dec_data=3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 15 cycles after out_valid -> dec_data and out_valid stable, in_ready=0; pulse out_ready -> IDLE next cycle.
- Busy ignore: toggle in_valid with random data/key during KEYEXP and ROUND -> result still equals the C.1 plaintext.
- Reset mid-ROUND: assert rst at cycle 15 -> immediately out_valid=0, in_ready=1, dec_data=0; a following C.1 run gives the correct result.
- With AES_DEC_KEY_CACHE_EN: run two back-to-back C.1 decryptions -> second has out_valid 11 edges after accept, correct plaintext; a different key next -> 21 edges.
